// File: rtl/mips_sim_pkg.sv
// Shared types and constants for the mips run controller and its PC-stuck detector.
// Optional trace output is controlled by MIPS_RUN_CTRL_TRACE_EN (see mips_run_ctrl).
package mips_sim_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RESET = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } run_state_e;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_HALT    = 2'd1;
  localparam logic [1:0] CAUSE_STUCK   = 2'd2;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

  localparam int DEF_RST_CYCLES  = 2;
  localparam int DEF_MAX_CYCLES  = 25000;
  localparam int DEF_STUCK_LIMIT = 8;
  localparam int DEF_PC_W        = 32;
  localparam int DEF_CNT_W       = 32;

  // Bits needed to hold the values 0 .. n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mips_pc_stuck_det.sv
// Flags a PC that has held the same value for STUCK_LIMIT consecutive enabled cycles.
// STUCK_LIMIT = 0 removes the detector entirely (stuck tied low).
module mips_pc_stuck_det
  import mips_sim_pkg::*;
#(
  parameter int STUCK_LIMIT = DEF_STUCK_LIMIT,
  parameter int PC_W        = DEF_PC_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic [PC_W-1:0] pc,
  output logic            stuck
);

  localparam int CW = cnt_width(STUCK_LIMIT);

  generate
    if (STUCK_LIMIT > 0) begin : g_det
      localparam logic [CW-1:0] CNT_MAX = CW'(STUCK_LIMIT - 1);

      logic [PC_W-1:0] prev_pc_q, prev_pc_d;
      logic            valid_q, valid_d;
      logic [CW-1:0]   cnt_q, cnt_d;
      logic            changed;

      // The counter holds the number of repeats after the first sighting of a pc,
      // so reaching STUCK_LIMIT-1 means STUCK_LIMIT cycles on the same pc.
      always_comb begin
        changed   = !valid_q || (pc != prev_pc_q);
        prev_pc_d = prev_pc_q;
        valid_d   = 1'b0;
        cnt_d     = '0;
        if (en) begin
          valid_d   = 1'b1;
          prev_pc_d = pc;
          if (changed) begin
            cnt_d = '0;
          end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
          end else begin
            cnt_d = cnt_q;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (!reset) begin
          prev_pc_q <= '0;
          valid_q   <= 1'b0;
          cnt_q     <= '0;
        end else begin
          prev_pc_q <= prev_pc_d;
          valid_q   <= valid_d;
          cnt_q     <= cnt_d;
        end
      end

      assign stuck = en && (cnt_d == CNT_MAX);
    end else begin : g_off
      assign stuck = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/mips_run_ctrl.sv
// Run controller for the mips core: reset sequencing, clock enable, run-cycle count and end detection.
// Define MIPS_RUN_CTRL_TRACE_EN to add the last_pc output and a completion message in simulation.
module mips_run_ctrl
  import mips_sim_pkg::*;
#(
  parameter int RST_CYCLES  = DEF_RST_CYCLES,
  parameter int MAX_CYCLES  = DEF_MAX_CYCLES,
  parameter int STUCK_LIMIT = DEF_STUCK_LIMIT,
  parameter int PC_W        = DEF_PC_W,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             halt_req,
  input  logic [PC_W-1:0]  pc,
  output logic             core_reset,
  output logic             core_en,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic             stuck,
  output logic [CNT_W-1:0] cycle_cnt
`ifdef MIPS_RUN_CTRL_TRACE_EN
  ,
  output logic [PC_W-1:0]  last_pc
`endif
);

  localparam int RW = cnt_width(RST_CYCLES);

  run_state_e       state_q, state_d;
  logic [RW-1:0]    rst_cnt_q, rst_cnt_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic             timeout_q, timeout_d;
  logic             stuck_q, stuck_d;
  logic             stuck_hit;
  logic [1:0]       cause;

  mips_pc_stuck_det #(
    .STUCK_LIMIT(STUCK_LIMIT),
    .PC_W       (PC_W)
  ) u_stuck_det (
    .clk  (clk),
    .reset(reset),
    .en   (state_q == ST_RUN),
    .pc   (pc),
    .stuck(stuck_hit)
  );

  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    cycle_cnt_d = cycle_cnt_q;
    timeout_d   = timeout_q;
    stuck_d     = stuck_q;
    cause       = CAUSE_NONE;
    core_reset  = 1'b0;
    core_en     = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        core_reset = (state_q == ST_IDLE);
        done       = (state_q == ST_DONE);
        if (start) begin
          state_d     = ST_RESET;
          rst_cnt_d   = RW'(RST_CYCLES - 1);
          cycle_cnt_d = '0;
          timeout_d   = 1'b0;
          stuck_d     = 1'b0;
        end
      end
      ST_RESET: begin
        core_reset = 1'b1;
        busy       = 1'b1;
        if (rst_cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          rst_cnt_d = rst_cnt_q - RW'(1);
        end
      end
      ST_RUN: begin
        core_en = 1'b1;
        busy    = 1'b1;
        if (cycle_cnt_q != '1) begin
          cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
        end
        // The terminating cycle is still counted, so a timeout leaves cycle_cnt = MAX_CYCLES.
        if (halt_req) begin
          cause = CAUSE_HALT;
        end else if (stuck_hit) begin
          cause = CAUSE_STUCK;
        end else if (cycle_cnt_q == CNT_W'(MAX_CYCLES - 1)) begin
          cause = CAUSE_TIMEOUT;
        end
        if (cause != CAUSE_NONE) begin
          state_d   = ST_DONE;
          timeout_d = (cause == CAUSE_TIMEOUT);
          stuck_d   = (cause == CAUSE_STUCK);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      rst_cnt_q   <= '0;
      cycle_cnt_q <= '0;
      timeout_q   <= 1'b0;
      stuck_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
      timeout_q   <= timeout_d;
      stuck_q     <= stuck_d;
    end
  end

  assign timeout   = timeout_q;
  assign stuck     = stuck_q;
  assign cycle_cnt = cycle_cnt_q;

`ifdef MIPS_RUN_CTRL_TRACE_EN
  logic [PC_W-1:0] last_pc_q, last_pc_d;

  always_comb begin
    last_pc_d = last_pc_q;
    if (state_q == ST_RUN && state_d == ST_DONE) begin
      last_pc_d = pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_pc_q <= '0;
    end else begin
      last_pc_q <= last_pc_d;
    end
  end

  assign last_pc = last_pc_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (reset && state_q == ST_RUN && state_d == ST_DONE) begin
      $display("mips_run_ctrl: run ended cycles=%0d cause=%0d last_pc=0x%08h",
               cycle_cnt_d, cause, pc);
    end
  end
`endif
`endif

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Self-checking bench for mips_run_ctrl: vector table, directed end-of-run sequences and
// randomized traffic compared every cycle against a run-level behavioural model.
module tb_mips_run_ctrl;

  localparam int RST_CYCLES  = 2;
  localparam int MAX_CYCLES  = 100;
  localparam int STUCK_LIMIT = 8;
  localparam int PC_W        = 32;
  localparam int CNT_W       = 32;
  localparam logic [31:0] PC_BASE = 32'h0040_0004;

  localparam int M_IDLE = 0;
  localparam int M_RST  = 1;
  localparam int M_RUN  = 2;
  localparam int M_DONE = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             halt_req;
  logic [PC_W-1:0]  pc;
  logic             core_reset, core_en, busy, done, timeout, stuck;
  logic [CNT_W-1:0] cycle_cnt;
`ifdef MIPS_RUN_CTRL_TRACE_EN
  logic [PC_W-1:0]  last_pc;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model: run phase, remaining reset cycles, run cycles, current same-pc run length.
  int          m_mode = M_IDLE;
  int          m_left = 0;
  int          m_cnt  = 0;
  int          m_len  = 0;
  bit          m_first = 1'b0;
  bit          m_to = 1'b0;
  bit          m_st = 1'b0;
  logic [31:0] m_prev = '0;

  always #5 clk = ~clk;

  mips_run_ctrl #(
    .RST_CYCLES (RST_CYCLES),
    .MAX_CYCLES (MAX_CYCLES),
    .STUCK_LIMIT(STUCK_LIMIT),
    .PC_W       (PC_W),
    .CNT_W      (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (rst_n),
    .start     (start),
    .halt_req  (halt_req),
    .pc        (pc),
    .core_reset(core_reset),
    .core_en   (core_en),
    .busy      (busy),
    .done      (done),
    .timeout   (timeout),
    .stuck     (stuck),
    .cycle_cnt (cycle_cnt)
`ifdef MIPS_RUN_CTRL_TRACE_EN
    ,
    .last_pc   (last_pc)
`endif
  );

  typedef struct {
    bit          r;
    bit          s;
    bit          h;
    logic [31:0] p;
    logic [5:0]  flags;  // {core_reset, core_en, busy, done, timeout, stuck}
    int          cnt;
  } vec_t;

  vec_t tbl[15];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit s, input bit h, input logic [31:0] p);
    if (!r) begin
      m_mode = M_IDLE;
      m_cnt  = 0;
      m_to   = 1'b0;
      m_st   = 1'b0;
      return;
    end
    case (m_mode)
      M_IDLE, M_DONE: begin
        if (s) begin
          m_mode = M_RST;
          m_left = RST_CYCLES;
          m_cnt  = 0;
          m_to   = 1'b0;
          m_st   = 1'b0;
        end
      end
      M_RST: begin
        m_left--;
        if (m_left == 0) begin
          m_mode  = M_RUN;
          m_first = 1'b1;
        end
      end
      default: begin
        m_len   = (m_first || p != m_prev) ? 1 : m_len + 1;
        m_first = 1'b0;
        m_prev  = p;
        m_cnt++;
        if (h) begin
          m_mode = M_DONE;
        end else if (STUCK_LIMIT > 0 && m_len >= STUCK_LIMIT) begin
          m_mode = M_DONE;
          m_st   = 1'b1;
        end else if (m_cnt == MAX_CYCLES) begin
          m_mode = M_DONE;
          m_to   = 1'b1;
        end
      end
    endcase
  endtask

  task automatic step(input bit r, input bit s, input bit h, input logic [31:0] p);
    logic [37:0] got_v, exp_v;
    rst_n    = r;
    start    = s;
    halt_req = h;
    pc       = p;
    @(posedge clk);
    #1;
    model_edge(r, s, h, p);
    got_v = {core_reset, core_en, busy, done, timeout, stuck, cycle_cnt};
    exp_v = {m_mode <= M_RST, m_mode == M_RUN, m_mode == M_RST || m_mode == M_RUN,
             m_mode == M_DONE, m_to, m_st, 32'(m_cnt)};
    check("model", 64'(got_v), 64'(exp_v));
  endtask

  // Starts from IDLE/DONE, runs with pc advancing by 4 until hold_from, optional halt at run cycle halt_at.
  task automatic run_seq(input string name, input int hold_from, input int halt_at,
                         input int exp_cnt, input bit exp_to, input bit exp_st);
    int n = 0;
    int k = 0;
    int rcount;
    step(1'b1, 1'b1, 1'b0, PC_BASE);
    check({name, " restart cnt"}, 64'(cycle_cnt), 64'd0);
    check({name, " restart flags"}, 64'({busy, timeout, stuck}), 64'b100);
    rcount = core_reset ? 1 : 0;
    while (!core_en && n < 10) begin
      step(1'b1, 1'b0, 1'b0, PC_BASE);
      if (core_reset) rcount++;
      n++;
    end
    check({name, " reset len"}, 64'(rcount), 64'(RST_CYCLES));
    while (!done && k < 300) begin
      step(1'b1, 1'b0, k == halt_at, PC_BASE + 32'(4 * ((k < hold_from) ? k : hold_from)));
      k++;
    end
    check({name, " done"}, 64'({done, core_en, busy}), 64'b100);
    check({name, " flags"}, 64'({timeout, stuck}), 64'({exp_to, exp_st}));
    check({name, " cnt"}, 64'(cycle_cnt), 64'(exp_cnt));
    $display("seq %s: cycle_cnt=%0d timeout=%0b stuck=%0b", name, cycle_cnt, timeout, stuck);
  endtask

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rp;
    int n;
    rst_n    = 1'b0;
    start    = 1'b0;
    halt_req = 1'b0;
    pc       = '0;

    //             r     s     h     p      flags     cnt
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 32'h0, 6'b100000, 0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 32'h0, 6'b100000, 0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 32'h0, 6'b100000, 0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 32'h0, 6'b101000, 0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 32'h0, 6'b101000, 0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 32'h0, 6'b011000, 0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 32'h0, 6'b011000, 1};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 32'h0, 6'b011000, 2};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 32'h0, 6'b011000, 3};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 32'h0, 6'b000100, 4};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 32'h0, 6'b000100, 4};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 32'h0, 6'b101000, 0};
    tbl[12] = '{1'b1, 1'b0, 1'b1, 32'h0, 6'b101000, 0};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 32'h0, 6'b011000, 0};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 32'h0, 6'b011000, 1};
    for (int i = 0; i < 15; i++) tbl[i].p = 32'h0040_0000 + 32'(4 * i);

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].r, tbl[i].s, tbl[i].h, tbl[i].p);
      check($sformatf("vec%0d flags", i),
            64'({core_reset, core_en, busy, done, timeout, stuck}), 64'(tbl[i].flags));
      check($sformatf("vec%0d cnt", i), 64'(cycle_cnt), 64'(tbl[i].cnt));
      $display("vec %0d: flags=%b cycle_cnt=%0d", i,
               {core_reset, core_en, busy, done, timeout, stuck}, cycle_cnt);
    end

    step(1'b0, 1'b0, 1'b0, PC_BASE);
    run_seq("timeout",         1000, -1, MAX_CYCLES, 1'b1, 1'b0);
    run_seq("stuck",             19, -1, 27,         1'b0, 1'b1);
    run_seq("halt_vs_timeout", 1000, 99, MAX_CYCLES, 1'b0, 1'b0);
    run_seq("halt_vs_stuck",     19, 26, 27,         1'b0, 1'b0);
    run_seq("stuck_vs_timeout",  92, -1, MAX_CYCLES, 1'b0, 1'b1);
    run_seq("const_pc",           0, -1, STUCK_LIMIT, 1'b0, 1'b1);

    // Reset asserted 50 cycles into a run.
    step(1'b1, 1'b1, 1'b0, PC_BASE);
    n = 0;
    while (!core_en && n < 10) begin
      step(1'b1, 1'b0, 1'b0, PC_BASE);
      n++;
    end
    for (int k = 0; k < 50; k++) step(1'b1, 1'b0, 1'b0, PC_BASE + 32'(4 * k));
    check("midrun cnt before", 64'(cycle_cnt), 64'd50);
    step(1'b0, 1'b0, 1'b0, PC_BASE);
    check("midrun outputs", 64'({core_reset, core_en, busy, done, timeout, stuck}),
          64'b100000);
    check("midrun cnt", 64'(cycle_cnt), 64'd0);
    $display("seq midrun_reset: core_reset=%0b busy=%0b cycle_cnt=%0d",
             core_reset, busy, cycle_cnt);

    rp = PC_BASE;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) rp = rp + 32'd4;
      step($urandom_range(0, 299) != 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 63) == 0, rp);
    end
    $display("random: 3000 cycles compared against model");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
